// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector.
// A PAT_W-bit pattern (MSB received first) is compared against the last
// PAT_W-1 accepted bits plus the bit currently on 'in'. The Mealy output
// 'out' fires in the completing cycle, 'out_q' is its registered copy, and
// 'match_cnt' is a saturating count of matches since reset or pattern load.
module seq_detect_param #(
  parameter int unsigned        PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1001,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] match_cnt
);

  // Fill counter only needs to reach PAT_W-1; keep at least one bit.
  localparam int unsigned      FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Saturating increment for the match counter: never wraps to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  // History fill level grows by one per accepted bit and sticks at full.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] value);
    if (value == FILL_FULL) begin
      return value;
    end else begin
      return value + FILL_W'(1);
    end
  endfunction

  // Registered state
  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-2:0] hist_r;
  logic [FILL_W-1:0] fill_r;
  logic             out_q_r;
  logic [CNT_W-1:0] match_cnt_r;

  // Combinational helpers
  logic [PAT_W-1:0] window_s;
  logic             full_s;
  logic             hit_s;
  logic             out_s;
  logic [PAT_W-1:0] pat_nxt_s;
  logic [PAT_W-2:0] hist_nxt_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Mealy match: full history plus the live bit equals the stored pattern.
  // Reset and load both suppress the output and discard the live bit.
  always_comb begin
    window_s = {hist_r, in};
    full_s   = (fill_r == FILL_FULL);
    hit_s    = (window_s == pat_r);
    if (rst || pat_load || !en) begin
      out_s = 1'b0;
    end else begin
      out_s = full_s & hit_s;
    end
  end

  // Next-state for pattern, history and fill; load wins over data.
  always_comb begin
    pat_nxt_s  = pat_r;
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    if (pat_load) begin
      pat_nxt_s  = pat_in;
      hist_nxt_s = {(PAT_W-1){1'b0}};
      fill_nxt_s = {FILL_W{1'b0}};
    end else if (en) begin
      if (out_s && (OVERLAP == 1'b0)) begin
        // Non-overlapping mode: a match consumes the whole window.
        hist_nxt_s = {(PAT_W-1){1'b0}};
        fill_nxt_s = {FILL_W{1'b0}};
      end else begin
        hist_nxt_s = window_s[PAT_W-2:0];
        fill_nxt_s = fill_inc(fill_r);
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end
  end

  // Next-state for the saturating match counter; load clears it.
  always_comb begin
    cnt_nxt_s = match_cnt_r;
    if (pat_load) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (out_s) begin
      cnt_nxt_s = sat_inc(match_cnt_r);
    end else begin
      cnt_nxt_s = match_cnt_r;
    end
  end

  // State update with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r       <= PATTERN;
      hist_r      <= {(PAT_W-1){1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      out_q_r     <= 1'b0;
      match_cnt_r <= {CNT_W{1'b0}};
    end else begin
      pat_r       <= pat_nxt_s;
      hist_r      <= hist_nxt_s;
      fill_r      <= fill_nxt_s;
      out_q_r     <= out_s;
      match_cnt_r <= cnt_nxt_s;
    end
  end

  assign out       = out_s;
  assign out_q     = out_q_r;
  assign match_cnt = match_cnt_r;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable serial sequence detector; the next generation of the fixed 4-bit Mealy detectors in the FSM library. It watches a 1-bit serial stream, one bit per enabled clock. It flags every occurrence of a PAT_W-bit pattern with a combinational Mealy output and a registered Moore-style output. Overlap is selectable, the pattern can be reloaded at runtime, and matches are counted with saturation for status readout.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1001: reset value of the pattern register; MSB is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history cleared after each match.
- CNT_W, 8: width of the match counter.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial data bit; sampled at the rising edge when en=1.
- en  input  1  bit-valid qualifier; when en=0 the bit is ignored and all state holds.
- pat_load  input  1  loads pat_in into the pattern register at the next edge.
- pat_in  input  PAT_W  new pattern; MSB is the first bit of the sequence.
- out  output  1  Mealy match; combinational, high during the cycle whose (en, in) completes a match.
- out_q  output  1  registered match; out delayed by one clock.
- match_cnt  output  CNT_W  number of matches since reset or last pattern load; saturates at all-ones.

## Operation
- State registers:
  - pat_r[PAT_W-1:0]: pattern.
  - hist[PAT_W-2:0]: last PAT_W-1 accepted bits, newest in bit 0.
  - fill[0..PAT_W-1]: count of valid history bits.
  - out_q.
  - match_cnt.
- Match condition: out = en & ~pat_load & (fill == PAT_W-1) & ({hist, in} == pat_r).
- On an edge with en=1 and pat_load=0:
  - If out=1 and OVERLAP=0: hist <= 0, fill <= 0.
  - Otherwise: hist <= {hist[PAT_W-3:0], in}, and fill <= min(fill+1, PAT_W-1).
- en=0: hist, fill and pat_r hold; out=0.
- match_cnt increments on every edge where out=1. At all-ones it holds; there is no wrap.
- pat_load=1 has priority over en:
  - pat_r <= pat_in; hist <= 0; fill <= 0; match_cnt <= 0.
  - out is forced 0 and the current in bit is discarded.
- out_q <= out on every edge, including pat_load and en=0 edges. Reset clears it.
- Reset (rst=1 at an edge) has priority over everything:
  - pat_r <= PATTERN; hist <= 0; fill <= 0; out_q <= 0; match_cnt <= 0.
  - out is 0 while rst=1.
- Reset or load mid-sequence discards the partial match. A full PAT_W fresh bits are needed before the next match.
- All-zero and all-one patterns are legal.
  - OVERLAP=1 with all-ones: matches on every bit after the first PAT_W-1.
  - OVERLAP=0 with all-ones: one match per PAT_W bits.

## Timing
- Latency:
  - out: 0 cycles; it is asserted in the same cycle the final pattern bit is presented on in with en=1.
  - out_q: 1 cycle; high for exactly the clock after the completing edge.
  - match_cnt: updates at the completing edge, so it is visible 1 cycle after out.
- First possible match: on the PAT_W-th accepted bit after reset or load.
- out is purely a function of registered state plus in, en and pat_load. Upstream logic must keep in/en stable and glitch-free around the sampling edge.
- Back-to-back matches:
  - OVERLAP=1: minimum spacing is the pattern's self-overlap period; 1 bit for uniform patterns.
  - OVERLAP=0: minimum spacing is PAT_W bits.
- A new pattern takes effect for bits accepted from the edge after the pat_load edge.

## Test plan
- Defaults (1001, OVERLAP=1): rst for 2 cycles, then in = 1,0,0,1,0,0,1,1 with en=1.
  - out high on the 4th and 7th bits.
  - out_q high one cycle after each.
  - match_cnt = 2 at the end.
- OVERLAP=0, same stream:
  - only the 4th bit matches; the 7th does not.
  - match_cnt = 1.
- en gaps: 1,0,0,1 with en=0 for 3 cycles between every bit, in toggling randomly while en=0.
  - exactly one out pulse, on the final enabled '1'.
  - no pulses during en=0.
- Runtime load: pat_load with pat_in=4'b1101 in the middle of the partial sequence 1,0,0, then stream 1,1,0,1,1,0,1.
  - pre-load history is discarded; match_cnt = 0 after the load.
  - out high on the 4th and 7th bits.
  - match_cnt = 2.
- Saturation: CNT_W=2, pattern 4'b1111, OVERLAP=1, with 10 consecutive 1s.
  - out high on bits 4..10 (7 matches).
  - match_cnt stops at 3.
- Reset mid-operation: stream 1,0,0, assert rst for 1 cycle, then in=1.
  - no match; out_q = 0 and match_cnt = 0.
  - a following 1,0,0,1 matches once.
